// File: rtl/extbus_if.sv
// extbus_if: brings an asynchronous 6502-style register bus into the clk25 domain and queues writes in a 4-entry FIFO.
// Define EXTBUS_GLITCH_FILTER_EN to add a third strobe stage that rejects single-cycle strobe pulses (one extra cycle of latency).
module extbus_if (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       extbus_cs_n,
    input  logic       extbus_rd_n,
    input  logic       extbus_wr_n,
    input  logic [4:0] extbus_a,
    input  logic [7:0] extbus_d_in,
    output logic [7:0] extbus_d_out,
    output logic       extbus_d_oe,
    output logic [4:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       rd_done,
    output logic [4:0] rd_done_addr,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_overflow
);
    logic        s1_cs_n, s1_rd_n, s1_wr_n;
    logic [4:0]  s1_a;
    logic [7:0]  s1_d;
    logic        s2_cs_n, s2_rd_n, s2_wr_n;
    logic        s1_wr_act, s1_rd_act;
    logic [1:0]  act2;
    logic [1:0]  act_cur;
    logic [1:0]  act_q;
    logic [1:0]  armed;
    logic [1:0]  prime_cnt;
    logic        primed;
    logic        wr_end, rd_end;
    logic [4:0]  wr_sh_a, rd_sh_a;
    logic [7:0]  wr_sh_d;
    logic [12:0] fifo_mem [4];
    logic [1:0]  head, tail;
    logic [2:0]  count;
    logic        full, pop, push_ok;

    assign rd_addr      = extbus_a;
    assign extbus_d_out = rd_data;
    assign extbus_d_oe  = !extbus_cs_n && !extbus_rd_n;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            {s1_cs_n, s1_rd_n, s1_wr_n} <= 3'b111;
            {s2_cs_n, s2_rd_n, s2_wr_n} <= 3'b111;
            s1_a <= '0;
            s1_d <= '0;
        end else begin
            {s1_cs_n, s1_rd_n, s1_wr_n} <= {extbus_cs_n, extbus_rd_n, extbus_wr_n};
            {s2_cs_n, s2_rd_n, s2_wr_n} <= {s1_cs_n, s1_rd_n, s1_wr_n};
            s1_a <= extbus_a;
            s1_d <= extbus_d_in;
        end
    end

    assign s1_wr_act = !s1_cs_n && !s1_wr_n;
    assign s1_rd_act = !s1_cs_n && !s1_rd_n;
    assign act2      = {!s2_cs_n && !s2_rd_n, !s2_cs_n && !s2_wr_n};

`ifdef EXTBUS_GLITCH_FILTER_EN
    logic       s3_cs_n, s3_rd_n, s3_wr_n;
    logic [1:0] act3;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            {s3_cs_n, s3_rd_n, s3_wr_n} <= 3'b111;
        end else begin
            {s3_cs_n, s3_rd_n, s3_wr_n} <= {s2_cs_n, s2_rd_n, s2_wr_n};
        end
    end

    assign act3 = {!s3_cs_n && !s3_rd_n, !s3_cs_n && !s3_wr_n};
    // Follow stage 2 only after it has shown the same value twice in a row.
    assign act_cur = (act2 & act3) | (act_q & (act2 ^ act3));
`else
    assign act_cur = act2;
`endif

    // Arming waits until the strobe pipeline holds real bus samples, so an
    // access already running when reset releases is never reported.
    assign primed = (prime_cnt == 2'd3);
    assign wr_end = armed[0] && act_q[0] && !act_cur[0];
    assign rd_end = armed[1] && act_q[1] && !act_cur[1];

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt    <= '0;
            act_q        <= '0;
            armed        <= '0;
            wr_sh_a      <= '0;
            wr_sh_d      <= '0;
            rd_sh_a      <= '0;
            rd_done      <= 1'b0;
            rd_done_addr <= '0;
        end else begin
            if (!primed) prime_cnt <= prime_cnt + 2'd1;
            act_q <= act_cur;
            armed <= armed | ({2{primed}} & ~act_cur);
            if (s1_wr_act) begin
                wr_sh_a <= s1_a;
                wr_sh_d <= s1_d;
            end
            if (s1_rd_act) rd_sh_a <= s1_a;
            rd_done <= rd_end;
            if (rd_end) rd_done_addr <= rd_sh_a;
        end
    end

    assign full     = (count == 3'd4);
    assign pop      = wr_valid && wr_ready;
    assign push_ok  = wr_end && (!full || pop);
    assign wr_valid = (count != 3'd0);
    assign wr_addr  = fifo_mem[head][12:8];
    assign wr_data  = fifo_mem[head][7:0];

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            wr_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_mem[tail] <= {wr_sh_a, wr_sh_d};
                tail           <= tail + 2'd1;
            end
            if (pop) head <= head + 2'd1;
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase
            if (wr_end && full && !pop) wr_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_extbus_if.sv
// tb_extbus_if: directed and randomized bus traffic against a transaction-level model of extbus_if.
`timescale 1ns/1ps
module tb_extbus_if;
`ifdef EXTBUS_GLITCH_FILTER_EN
    localparam int LAT          = 3;
    localparam int MINLEN       = 2;
    localparam int GLITCH_BEATS = 0;
`else
    localparam int LAT          = 2;
    localparam int MINLEN       = 1;
    localparam int GLITCH_BEATS = 1;
`endif

    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic       extbus_cs_n = 1'b1, extbus_rd_n = 1'b1, extbus_wr_n = 1'b1;
    logic [4:0] extbus_a = '0;
    logic [7:0] extbus_d_in = '0;
    logic [7:0] extbus_d_out;
    logic       extbus_d_oe;
    logic [4:0] rd_addr;
    logic [7:0] rd_data = '0;
    logic       rd_done;
    logic [4:0] rd_done_addr;
    logic       wr_valid;
    logic       wr_ready = 1'b0;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_mode = 1'b0;

    always #20 clk25 = ~clk25;

    extbus_if dut (
        .clk25(clk25), .rst_n(rst_n),
        .extbus_cs_n(extbus_cs_n), .extbus_rd_n(extbus_rd_n), .extbus_wr_n(extbus_wr_n),
        .extbus_a(extbus_a), .extbus_d_in(extbus_d_in),
        .extbus_d_out(extbus_d_out), .extbus_d_oe(extbus_d_oe),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_done(rd_done), .rd_done_addr(rd_done_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_overflow(wr_overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an access ends at the first inactive bus sample; its effect lands LAT edges later.
    typedef struct { int due; logic [4:0] a; logic [7:0] d; } ev_t;
    ev_t         wq[$];
    ev_t         rq[$];
    logic [12:0] mq[$];
    logic        m_ovf = 1'b0, m_rd_done = 1'b0;
    logic [4:0]  m_rd_done_addr = '0;
    bit          m_w_armed, m_r_armed, m_w_run_armed, m_r_run_armed;
    int          m_w_run, m_r_run;
    logic [4:0]  m_w_a, m_r_a;
    logic [7:0]  m_w_d;

    always @(posedge clk25) begin
        bit   pop, full, wa, ra, push;
        ev_t  e;
        cyc++;
        if (!rst_n) begin
            wq.delete(); rq.delete(); mq.delete();
            m_ovf = 1'b0; m_rd_done = 1'b0; m_rd_done_addr = '0;
            m_w_armed = 0; m_r_armed = 0; m_w_run = 0; m_r_run = 0;
        end else begin
            full = (mq.size() == 4);
            pop  = (mq.size() != 0) && wr_ready;
            push = (wq.size() != 0) && (wq[0].due == cyc);
            if (pop) void'(mq.pop_front());
            if (push) begin
                e = wq.pop_front();
                if (full && !pop) m_ovf = 1'b1;
                else mq.push_back({e.a, e.d});
            end
            m_rd_done = (rq.size() != 0) && (rq[0].due == cyc);
            if (m_rd_done) begin
                e = rq.pop_front();
                m_rd_done_addr = e.a;
            end
            wa = !extbus_cs_n && !extbus_wr_n;
            ra = !extbus_cs_n && !extbus_rd_n;
            if (wa) begin
                if (m_w_run == 0) m_w_run_armed = m_w_armed;
                m_w_run++;
                m_w_a = extbus_a;
                m_w_d = extbus_d_in;
            end else begin
                if (m_w_run >= MINLEN && m_w_run_armed) begin
                    e.due = cyc + LAT; e.a = m_w_a; e.d = m_w_d;
                    wq.push_back(e);
                end
                m_w_run = 0;
                m_w_armed = 1;
            end
            if (ra) begin
                if (m_r_run == 0) m_r_run_armed = m_r_armed;
                m_r_run++;
                m_r_a = extbus_a;
            end else begin
                if (m_r_run >= MINLEN && m_r_run_armed) begin
                    e.due = cyc + LAT; e.a = m_r_a; e.d = '0;
                    rq.push_back(e);
                end
                m_r_run = 0;
                m_r_armed = 1;
            end
        end
        #1;
        chk("wr_valid", int'(wr_valid), int'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("wr_addr", int'(wr_addr), int'(mq[0][12:8]));
            chk("wr_data", int'(wr_data), int'(mq[0][7:0]));
        end
        chk("wr_overflow", int'(wr_overflow), int'(m_ovf));
        chk("rd_done", int'(rd_done), int'(m_rd_done));
        chk("rd_done_addr", int'(rd_done_addr), int'(m_rd_done_addr));
        chk("d_oe", int'(extbus_d_oe), int'(!extbus_cs_n && !extbus_rd_n));
        chk("d_out", int'(extbus_d_out), int'(rd_data));
        chk("rd_addr", int'(rd_addr), int'(extbus_a));
    end

    task automatic tick();
        @(negedge clk25);
        if (rand_mode) begin
            wr_ready = 1'($urandom_range(0, 1));
            rd_data  = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [7:0] d, input int len);
        extbus_a = a; extbus_d_in = d;
        extbus_cs_n = 1'b0; extbus_wr_n = 1'b0;
        repeat (len) tick();
        extbus_cs_n = 1'b1; extbus_wr_n = 1'b1;
    endtask

    task automatic bus_read(input logic [4:0] a, input int len);
        extbus_a = a;
        extbus_cs_n = 1'b0; extbus_rd_n = 1'b0;
        repeat (len) tick();
        extbus_cs_n = 1'b1; extbus_rd_n = 1'b1;
    endtask

    task automatic fill4();
        for (int i = 0; i < 4; i++) begin
            bus_write(5'd4, 8'hA1 + 8'(i), 2);
            repeat (4) tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_wr_valid", int'(wr_valid), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_wr_overflow", int'(wr_overflow), 0);
        chk("rst_rd_done", int'(rd_done), 0);
        rst_n = 1'b1;
        repeat (6) tick();

        // single write, exact latency
        wr_ready = 1'b1;
        bus_write(5'd5, 8'h01, 3);
        repeat (LAT) tick();
        chk("lat_early_valid", int'(wr_valid), 0);
        tick();
        chk("lat_valid", int'(wr_valid), 1);
        chk("lat_addr", int'(wr_addr), 5);
        chk("lat_data", int'(wr_data), 8'h01);
        tick();
        chk("single_beat", int'(wr_valid), 0);

        // fill, drop on full, drain in order
        wr_ready = 1'b0;
        fill4();
        chk("full_valid", int'(wr_valid), 1);
        chk("full_head", int'(wr_data), 8'hA1);
        chk("full_ovf", int'(wr_overflow), 0);
        bus_write(5'd4, 8'hA5, 2);
        repeat (LAT + 1) tick();
        chk("drop_ovf", int'(wr_overflow), 1);
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", int'(wr_valid), 1);
            chk("drain_data", int'(wr_data), 8'hA1 + i);
            tick();
        end
        chk("drain_empty", int'(wr_valid), 0);
        chk("ovf_sticky", int'(wr_overflow), 1);
        wr_ready = 1'b0;
        do_reset();
        chk("ovf_cleared", int'(wr_overflow), 0);

        // push while full with simultaneous pop
        fill4();
        bus_write(5'd4, 8'hA5, 2);
        repeat (LAT) tick();
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        chk("pushpop_ovf", int'(wr_overflow), 0);
        chk("pushpop_head", int'(wr_data), 8'hA2);
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pp_drain_data", int'(wr_data), 8'hA2 + i);
            tick();
        end
        chk("pp_drain_empty", int'(wr_valid), 0);

        // read
        rd_data = 8'hA1;
        chk("idle_d_oe", int'(extbus_d_oe), 0);
        extbus_a = 5'd4; extbus_cs_n = 1'b0; extbus_rd_n = 1'b0;
        tick();
        chk("rd_d_oe", int'(extbus_d_oe), 1);
        chk("rd_d_out", int'(extbus_d_out), 8'hA1);
        chk("rd_rd_addr", int'(rd_addr), 4);
        repeat (2) tick();
        extbus_cs_n = 1'b1; extbus_rd_n = 1'b1;
        n = 0;
        repeat (8) begin tick(); if (rd_done) n++; end
        chk("rd_done_pulses", n, 1);
        chk("rd_done_addr4", int'(rd_done_addr), 4);

        // reset in the middle of a write
        extbus_a = 5'd1; extbus_d_in = 8'h40; extbus_cs_n = 1'b0; extbus_wr_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", int'(wr_valid), 0);
        chk("mid_rst_addr", int'(wr_addr), 0);
        chk("mid_rst_data", int'(wr_data), 0);
        chk("mid_rst_ovf", int'(wr_overflow), 0);
        chk("mid_rst_rd_done_addr", int'(rd_done_addr), 0);
        rst_n = 1'b1;
        repeat (5) tick();
        extbus_cs_n = 1'b1; extbus_wr_n = 1'b1;
        n = 0;
        repeat (8) begin tick(); if (wr_valid) n++; end
        chk("mid_rst_no_beat", n, 0);

        // single-sample write strobe
        bus_write(5'd7, 8'h5A, 1);
        n = 0;
        repeat (8) begin tick(); if (wr_valid && wr_addr == 5'd7 && wr_data == 8'h5A) n++; end
        chk("glitch_beats", n, GLITCH_BEATS);

        // randomized traffic
        rand_mode = 1'b1;
        for (int t = 0; t < 150; t++) begin
            int kind, len;
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 4));
            if (kind <= 5) begin
                bus_write(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), len);
            end else if (kind <= 7) begin
                bus_read(5'($urandom_range(0, 31)), len);
            end else if (kind == 8) begin
                extbus_a = 5'($urandom_range(0, 31));
                extbus_wr_n = 1'b0; extbus_rd_n = 1'($urandom_range(0, 1));
                repeat (len) tick();
                extbus_wr_n = 1'b1; extbus_rd_n = 1'b1;
            end else begin
                extbus_cs_n = 1'b0;
                repeat (len) tick();
                extbus_cs_n = 1'b1;
            end
            repeat ($urandom_range(3, 6)) tick();
        end
        rand_mode = 1'b0;
        wr_ready = 1'b1;
        repeat (12) tick();
        chk("final_empty", int'(wr_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/extbus_if.md
EXTBUS_IF -- requirements
Module: extbus_if

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), clock and reset first:
- clk25  in  1  sole clock; 25 MHz system clock
- rst_n  in  1  asynchronous, active-low reset
- extbus_cs_n  in  1  6502 chip select, async to clk25
- extbus_rd_n  in  1  read strobe, async
- extbus_wr_n  in  1  write strobe, async
- extbus_a  in  5  register address, async
- extbus_d_in  in  8  bus data from CPU
- extbus_d_out  out  8  bus data to CPU
- extbus_d_oe  out  1  data output enable
- rd_addr  out  5  read address to register file
- rd_data  in  8  register file read data
- rd_done  out  1  one-cycle pulse at end of read access
- rd_done_addr  out  5  address of completed read
- wr_valid  out  1  write beat valid
- wr_ready  in  1  downstream accepts write beat
- wr_addr  out  5  write beat address
- wr_data  out  8  write beat data
- wr_overflow  out  1  sticky: write dropped

Function
REQ-002 SHALL drive rd_addr = extbus_a, extbus_d_out = rd_data, extbus_d_oe = !extbus_cs_n & !extbus_rd_n, all combinational.
REQ-003 SHALL sample cs_n, rd_n, wr_n, a, d_in into an input register (stage 1) every clk25 cycle, then pass the strobes through a second flop (stage 2).
REQ-004 SHALL define write-active = !cs_n & !wr_n and read-active = !cs_n & !rd_n at stage 2.
REQ-005 SHALL hold a shadow of a/d taken from the last stage-1 sample with write-active true; a write commits the shadow.
REQ-006 SHALL detect end of write on the stage-2 write-active 1->0 transition and push {addr,data} into the FIFO in that cycle.
REQ-007 SHALL detect end of read on the stage-2 read-active 1->0 transition and assert rd_done for exactly one cycle, rd_done_addr = stage-1 address latched during the access.
REQ-008 SHALL implement a 4-entry write FIFO; wr_valid = not empty, wr_addr/wr_data = head entry; pop when wr_valid & wr_ready.
REQ-009 SHALL, on push while full without simultaneous pop, drop the push and set wr_overflow until reset.
REQ-010 SHALL, on push and pop in the same cycle while full, accept the push; wr_overflow unchanged.
REQ-011 SHALL preserve FIFO order; pointers wrap modulo 4; count range 0..4.
REQ-012 SHALL give write latency: wr_valid high in the 3rd clk25 cycle after the first stage-1 sample showing write inactive (FIFO empty).
REQ-013 SHALL recognise only accesses whose inactive->active edge was seen after reset release (armed flag).

Reset
REQ-014 SHALL, while rst_n=0, clear FIFO, pointers, shadow, wr_overflow, rd_done, rd_done_addr, and the armed flag; strobe flops reset to inactive (1).
REQ-015 SHALL reset wr_valid=0, wr_addr=0, wr_data=0; combinational outputs follow REQ-002.
REQ-016 SHALL NOT emit a beat or rd_done for an access in progress at reset deassertion.

Configuration
REQ-017 SHALL, with EXTBUS_GLITCH_FILTER_EN defined, add a stage-3 strobe flop and change strobe state only after two equal consecutive stage-2 samples; pulses of 1 cycle are ignored; latency +1 cycle (4th cycle).
REQ-018 SHALL, without EXTBUS_GLITCH_FILTER_EN, use stage-2 strobes directly per REQ-006/007.

Verification
REQ-019 Write a=5, d=0x01, wr_ready=1 -> exactly one beat addr 5 data 0x01, 3rd cycle after write-end sample (4th with filter).
REQ-020 Writes a=4 data A1,A2,A3,A4 with wr_ready=0 -> 4 entries, wr_overflow=0; wr_ready=1 -> A1..A4 popped one per cycle.
REQ-021 Fifth write 0xA5 while full, no pop -> dropped, wr_overflow=1 until reset; repeat with pop same cycle -> accepted, wr_overflow stays 0.
REQ-022 Read a=4, rd_data=0xA1 -> d_oe=1, d_out=0xA1 while rd_n low; single rd_done with rd_done_addr=4.
REQ-023 rst_n low mid-write (a=1, d=0x40), release while wr_n low -> all registered outputs 0, no beat emitted.
REQ-024 wr_n low for one clk25 sample -> pushed without macro; ignored with EXTBUS_GLITCH_FILTER_EN.
